// File: rtl/des_pkg.sv
// DES S-box constants shared by the substitution stage and its lookup cells.
// Tables are FIPS 46-3 S1..S8; each row is packed as 16 nibbles, column 0 in
// the leftmost nibble, so DES_SBOX[box][row][col] reads straight from the text.
package des_pkg;

    localparam int HALF_W = 32;  // DES half-block width
    localparam int EXP_W  = 48;  // E-expanded half-block / subkey width
    localparam int SBOX_N = 8;   // number of S-boxes

    localparam logic [0:7][0:3][0:15][3:0] DES_SBOX = '{
        // S1
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
          64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        // S2
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
          64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        // S3
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
          64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        // S4
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
          64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        // S5
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
          64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        // S6
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
          64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        // S7
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
          64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        // S8
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
          64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Row index is the outer bit pair of the 6-bit group (DES bits 1 and 6).
    function automatic logic [1:0] sbox_row(input logic [0:5] b);
        return {b[0], b[5]};
    endfunction

    // Column index is the inner four bits, first bit most significant.
    function automatic logic [3:0] sbox_col(input logic [0:5] b);
        return b[1:4];
    endfunction

endpackage

// File: rtl/des_sbox_lookup.sv
// One combinational DES S-box: 6-bit group in, 4-bit nibble out (MSB = first
// output bit). SBOX_IDX selects S1..S8 as 0..7.
module des_sbox_lookup
    import des_pkg::*;
#(
    parameter int SBOX_IDX = 0
) (
    input  logic [0:5] sel_i,
    output logic [3:0] nib_o
);

    logic [1:0] row;
    logic [3:0] col;

    // Pure table read; no state.
    always_comb begin
        row   = sbox_row(sel_i);
        col   = sbox_col(sel_i);
        nib_o = DES_SBOX[SBOX_IDX][row][col];
    end

endmodule

// File: rtl/des_sbox_stage.sv
// Two-register DES f-function substitution stage: key mix into stage 1,
// S-box substitution into stage 2, outputs driven straight from stage 2.
// Optional build macro DES_SBOX_PARITY_EN adds input parity checking with a
// sticky error flag and a parity bit travelling with the output word.
module des_sbox_stage
    import des_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:EXP_W-1]  in_expanded,
    input  logic [0:EXP_W-1]  in_subkey,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:HALF_W-1] out_data,
    output logic [TAG_W-1:0]  out_tag
`ifdef DES_SBOX_PARITY_EN
    ,
    input  logic              in_parity,
    output logic              out_parity,
    output logic              parity_err
`endif
);

    logic              s1_valid_q;
    logic [0:EXP_W-1]  s1_x_q, s1_x_d;
    logic [TAG_W-1:0]  s1_tag_q;
    logic              s2_valid_q;
    logic [0:HALF_W-1] s2_data_q, s2_data_d;
    logic [TAG_W-1:0]  s2_tag_q;
    logic              adv_s2;
    logic              load_s1;

    // Stage 2 moves whenever it is empty or being drained; stage 1 can take
    // a word whenever it is empty or its contents move on into stage 2.
    always_comb begin
        adv_s2   = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || adv_s2;
        load_s1  = in_valid && in_ready;
        s1_x_d   = in_expanded ^ in_subkey;
    end

    // Eight lookups between the two registers, one per 6-bit group.
    for (genvar j = 0; j < SBOX_N; j++) begin : g_sbox
        des_sbox_lookup #(.SBOX_IDX(j)) u_lookup (
            .sel_i (s1_x_q[6*j +: 6]),
            .nib_o (s2_data_d[4*j +: 4])
        );
    end

    // Stage 1: key-mixed word and its tag; empties when its word moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_tag_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_x_q   <= s1_x_d;
                s1_tag_q <= in_tag;
            end
        end
    end

    // Stage 2: substituted word; a bubble from stage 1 clears valid but
    // leaves the old data in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else if (adv_s2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

`ifdef DES_SBOX_PARITY_EN
    logic out_parity_q;
    logic parity_err_q;

    // Output parity rides with stage 2; the error flag latches on any
    // accepted word whose supplied parity disagrees with its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (adv_s2 && s1_valid_q)
                out_parity_q <= ^s2_data_d;
            if (load_s1 && (in_parity != ^in_expanded))
                parity_err_q <= 1'b1;
        end
    end

    assign out_parity = out_parity_q;
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_des_sbox_stage.sv
// Directed and randomly stalled stimulus against des_sbox_stage with a
// scoreboard of expected output words. Honours DES_SBOX_PARITY_EN.
module tb_des_sbox_stage;

    localparam int TAG_W = 4;

    // Reference FIPS 46-3 tables, one 256-bit string per box, row-major,
    // entry (row, col) at nibble index 16*row+col counted from the left.
    localparam logic [255:0] SB [0:7] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [0:47]       in_expanded;
    logic [0:47]       in_subkey;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [0:31]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              par_flip = 1'b0;
`ifdef DES_SBOX_PARITY_EN
    logic              in_parity;
    logic              out_parity;
    logic              parity_err;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int n_out    = 0;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    des_sbox_stage #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_expanded (in_expanded),
        .in_subkey   (in_subkey),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag)
`ifdef DES_SBOX_PARITY_EN
        ,
        .in_parity   (in_parity),
        .out_parity  (out_parity),
        .parity_err  (parity_err)
`endif
    );

    // Reference substitution: bit 47 of x is DES bit 1.
    function automatic logic [31:0] model(input logic [47:0] x);
        logic [5:0]   b;
        logic [1:0]   r;
        logic [3:0]   c;
        logic [255:0] t;
        logic [31:0]  res;
        res = '0;
        for (int j = 0; j < 8; j++) begin
            b = x[47-6*j -: 6];
            r = {b[5], b[0]};
            c = b[4:1];
            t = SB[j];
            res[31-4*j -: 4] = t[255-4*(16*int'(r)+int'(c)) -: 4];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the state that the next
    // rising edge will act on.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [TAG_W-1:0] prev_tag;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (prev_stall) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_data", 64'(out_data), 64'(prev_data));
                    check("hold_tag", 64'(out_tag), 64'(prev_tag));
                end
                check("in_ready", 64'(in_ready), 64'(!(sb_q.size() == 2 && !out_ready)));
                if (sb_q.size() == 0)
                    check("no_stale_valid", 64'(out_valid), 64'd0);
                if (out_valid && out_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_out++;
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_tag", 64'(out_tag), 64'(e.tag));
`ifdef DES_SBOX_PARITY_EN
                    check("sb_parity", 64'(out_parity), 64'(^e.data));
`endif
                end
                if (in_valid && in_ready)
                    sb_q.push_back('{data: model(in_expanded ^ in_subkey), tag: in_tag});
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_tag   = out_tag;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic drive(input logic [47:0] x, input logic [47:0] k, input logic [TAG_W-1:0] t);
        in_valid    = 1'b1;
        in_expanded = x;
        in_subkey   = k;
        in_tag      = t;
`ifdef DES_SBOX_PARITY_EN
        in_parity   = (^x) ^ par_flip;
`endif
    endtask

    // Present one word and hold it until accepted (bounded); returns 1 ns
    // after the accepting edge with in_valid dropped.
    task automatic send(input logic [47:0] x, input logic [47:0] k, input logic [TAG_W-1:0] t);
        int   c;
        logic acc;
        c   = 0;
        acc = 1'b0;
        drive(x, k, t);
        while (!acc && c < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'(in_ready), 64'd1);
    endtask

    // Wait (bounded) for an output word and compare it with a fixed value.
    task automatic expect_out(input string nm, input logic [31:0] d, input logic [TAG_W-1:0] t);
        int c;
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_valid"}, 64'(out_valid), 64'd1);
        check({nm, "_data"}, 64'(out_data), 64'(d));
        check({nm, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int          idx;
        int          cyc;
        int          target;
        logic        acc;
        logic [47:0] rx [16];
        logic [47:0] rk [16];

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_expanded = '0;
        in_subkey   = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
`ifdef DES_SBOX_PARITY_EN
        in_parity   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // All-zero word, latency: invisible one edge after accept, visible the next
        out_ready = 1'b1;
        send(48'h0, 48'h0, 4'd3);
        @(negedge clk);
        check("lat_edge1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge2_valid", 64'(out_valid), 64'd1);
        check("zero_data", 64'(out_data), 64'h0000_0000_EFA7_2C4D);
        check("zero_tag", 64'(out_tag), 64'd3);
        @(posedge clk);
        #1;

        // S1 only excited
        send(48'h6C00_0000_0000, 48'h0, 4'd5);
        expect_out("s1_only", 32'h5FA7_2C4D, 4'd5);

        // Key cancels data
        send(48'hA5A5_A5A5_A5A5, 48'hA5A5_A5A5_A5A5, 4'd7);
        expect_out("xor_cancel", 32'hEFA7_2C4D, 4'd7);

        // Fill both stages with output blocked, then drain and fill together
        out_ready = 1'b0;
        send(48'h0123_4567_89AB, 48'h1334_5779_9BBC, 4'd9);
        send(48'hFEDC_BA98_7654, 48'h0F1E_2D3C_4B5A, 4'd10);
        drive(48'hFFFF_FFFF_FFFF, 48'h0, 4'd11);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_fill_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Sixteen back-to-back words, tags 0..15, random output stalls
        for (int i = 0; i < 16; i++) begin
            rx[i] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
            rk[i] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
        end
        target = n_out + 16;
        idx    = 0;
        cyc    = 0;
        drive(rx[0], rk[0], 4'd0);
        while (n_out < target && cyc < 600) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 16) drive(rx[idx], rk[idx], TAG_W'(idx));
                else in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 64'(n_out), 64'(target));
        drain();

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        send(48'h1111_2222_3333, 48'h4444_5555_6666, 4'd12);
        send(48'h7777_8888_9999, 48'hAAAA_BBBB_CCCC, 4'd13);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(48'h0, 48'h0, 4'd14);
        expect_out("post_rst", 32'hEFA7_2C4D, 4'd14);

`ifdef DES_SBOX_PARITY_EN
        // One word with a wrong parity bit sets the sticky flag
        @(negedge clk);
        check("par_clean", 64'(parity_err), 64'd0);
        @(posedge clk);
        #1;
        par_flip = 1'b1;
        send(48'h0000_0000_0001, 48'h0, 4'd15);
        par_flip = 1'b0;
        @(negedge clk);
        check("par_err_set", 64'(parity_err), 64'd1);
        @(posedge clk);
        #1;
        send(48'h0000_0000_0003, 48'h0, 4'd1);
        repeat (4) @(posedge clk);
        #1;
        check("par_err_sticky", 64'(parity_err), 64'd1);
`endif

        drain();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
